pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer, the successor to the plain resettable flop used between CPU pipeline stages. It registers a WIDTH-bit payload between two stages at full throughput, absorbs one cycle of downstream back-pressure without a combinational ready path, and supports a synchronous flush for branch/exception squashing. It is instantiated at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- WIDTH, 32, payload width in bits (≥1)
- RESET_VAL, 0, value loaded into both data registers on reset and on flush (WIDTH bits)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all held entries (active-high)
- in_valid  input  1  upstream presents a payload
- in_ready  output  1  block can accept; registered, not a function of out_ready
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a live entry
- out_ready  input  1  downstream consumes this cycle
- out_data  output  WIDTH  head payload (main register)
- occupancy  output  2  entries held: 0, 1 or 2

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (drives out_data), skid register, 2-bit state.
- States: EMPTY (occupancy 0), ONE (1), FULL (2). Encoded state drives in_ready = (state != FULL), out_valid = (state != EMPTY), occupancy.
- EMPTY: push → ONE, main ← in_data; else stay.
- ONE: push & pop → ONE, main ← in_data; push & !pop → FULL, skid ← in_data; !push & pop → EMPTY; neither → stay.
- FULL: no push possible; pop → ONE, main ← skid; else stay.
- Payload order strictly FIFO; no entry duplicated or dropped except by flush.
- flush (with PIPE_SKID_FLUSH_EN) has priority over all: next state EMPTY, main and skid ← RESET_VAL; a push or pop coinciding with flush is discarded (upstream sees the push handshake complete but the payload is lost; downstream must ignore out_data that cycle if it qualifies with flush).
- in_data is sampled only on push; out_data is stable while out_valid & !out_ready.
- Reset (rst = 0, any time, asynchronous): state EMPTY, main = skid = RESET_VAL; outputs immediately in_ready = 1, out_valid = 0, occupancy = 0, out_data = RESET_VAL. Mid-transfer reset loses all entries.

## Timing
- Latency: payload pushed at edge N appears on out_data with out_valid = 1 after edge N (available to consume in cycle N+1).
- Throughput: one transfer per cycle sustained while out_ready = 1.
- in_ready deasserts the cycle after a push & !pop from ONE; reasserts the cycle after the pop from FULL.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.
- All state updates on rising clk; only rst acts asynchronously.

## Configuration
- PIPE_SKID_FLUSH_EN defined: flush port functional as described.
- Undefined: flush port present but ignored (no logic); state changes only by handshake and reset.

## Test plan
- Reset: hold rst = 0 with in_valid = 1, in_data = 0xDEADBEEF → in_ready = 1, out_valid = 0, occupancy = 0, out_data = RESET_VAL; release, first edge with push loads 0xDEADBEEF, out_valid = 1 next cycle.
- Streaming: in_valid = 1 with payloads 1..8 on consecutive cycles, out_ready = 1 → outputs 1..8 on consecutive cycles, one-cycle latency, occupancy constant 1, in_ready never low.
- Back-pressure: push A, B while out_ready = 0 → occupancy 2, in_ready = 0, out_data = A stable; raise out_ready → A then B delivered, in_ready = 1 the cycle after A pops.
- Simultaneous push/pop in ONE: hold X, push Y with out_ready = 1 → X consumed, out_data = Y next cycle, occupancy stays 1.
- Flush (macro defined): FULL with A, B, assert flush with in_valid = 1, out_ready = 1 → next cycle occupancy 0, out_valid = 0, out_data = RESET_VAL, neither B nor the new payload ever appears.
- Flush (macro undefined): same stimulus → flush ignored, A then the held/new entries delivered in order.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// Optional synchronous flush is compiled in when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits on ready, and both ready/valid here come from flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_next_main;
    logic [WIDTH-1:0] w_next_skid;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;

`ifdef PIPE_SKID_FLUSH_EN
    assign w_flush = flush;
`else
    logic w_unused_flush;
    assign w_unused_flush = flush;
    assign w_flush        = 1'b0;
`endif

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign occupancy = r_state;
    assign out_data  = r_main;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_main  = r_main;
        w_next_skid  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_next_state = ST_ONE;
                    w_next_main  = in_data;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_next_main = in_data;
                end else if (w_push) begin
                    w_next_state = ST_FULL;
                    w_next_skid  = in_data;
                end else if (w_pop) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_next_state = ST_ONE;
                    w_next_main  = r_skid;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
        // Squash wins over any handshake in the same cycle.
        if (w_flush) begin
            w_next_state = ST_EMPTY;
            w_next_main  = RESET_VAL;
            w_next_skid  = RESET_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_next_state;
            r_main  <= w_next_main;
            r_skid  <= w_next_skid;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus randomized traffic
// compared against a queue-based model of a two-entry FIFO stage.
module tb_pipe_skid_reg;

    localparam int               W    = 32;
    localparam logic [W-1:0]     RVAL = 32'hA5A5_0F0F;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks;
    int errors;

    // Reference model: ordered list of held entries plus the value shown on out_data.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_shown;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        exp_shown = RVAL;
    endtask

    // Driver: apply one cycle of inputs, advance to just after the edge, update model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic push;
        logic pop;
        logic fl;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        push = v && (exp_q.size() < 2);
        pop  = r && (exp_q.size() > 0);
`ifdef PIPE_SKID_FLUSH_EN
        fl = f;
`else
        fl = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            exp_shown = RVAL;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(d);
            if (exp_q.size() > 0) exp_shown = exp_q[0];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (out_data !== RVAL) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, RVAL); end
        rst = 1'b1;
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_push_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL first_push_data got %h exp deadbeef", out_data); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL first_push_occ got %0d exp 1", occupancy); end
        // Fill, then assert reset between edges: outputs must clear without a clock.
        cycle(1'b1, 32'h0000_1234, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL prefill_occ got %0d exp 2", occupancy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL async_reset_occ got %0d exp 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_data !== RVAL) begin errors++; $display("FAIL async_reset_data got %h exp %h", out_data, RVAL); end
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, W'(k), 1'b1, 1'b0);
            checks++; if (out_data !== W'(k)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", k, out_data, W'(k)); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_ctrl[%0d] got occ %0d rdy %b vld %b exp occ 1 rdy 1 vld 1", k, occupancy, in_ready, out_valid);
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got vld %b exp 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got occ %0d rdy %b exp occ 2 rdy 0", occupancy, in_ready);
        end
        checks++; if (out_data !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_head got %h exp aaaa0001", out_data); end
        cycle(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
        checks++; if (out_data !== 32'hAAAA_0001 || occupancy !== 2'd2) begin
            errors++; $display("FAIL bp_stable got %h occ %0d exp aaaa0001 occ 2", out_data, occupancy);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_data !== 32'hBBBB_0002 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++; $display("FAIL bp_pop_a got %h rdy %b occ %0d exp bbbb0002 rdy 1 occ 1", out_data, in_ready, occupancy);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL bp_pop_b got vld %b occ %0d exp vld 0 occ 0", out_valid, occupancy);
        end
    endtask

    task automatic test_push_pop();
        cycle(1'b1, 32'h1111_AAAA, 1'b0, 1'b0);
        cycle(1'b1, 32'h2222_BBBB, 1'b1, 1'b0);
        checks++; if (out_data !== 32'h2222_BBBB || occupancy !== 2'd1) begin
            errors++; $display("FAIL push_pop got %h occ %0d exp 2222bbbb occ 1", out_data, occupancy);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'h0000_00A1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_00B2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_00C3, 1'b1, 1'b1);
`ifdef PIPE_SKID_FLUSH_EN
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== RVAL) begin
            errors++; $display("FAIL flush_clear got occ %0d vld %b data %h exp occ 0 vld 0 data %h", occupancy, out_valid, out_data, RVAL);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak got vld %b exp 0", out_valid); end
`else
        checks++; if (occupancy !== 2'd1 || out_data !== 32'h0000_00B2) begin
            errors++; $display("FAIL noflush_b got occ %0d data %h exp occ 1 data 000000b2", occupancy, out_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL noflush_drain got vld %b exp 0", out_valid); end
`endif
    endtask

    task automatic test_random();
        logic         v, r, f;
        logic [W-1:0] d;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 19) == 0);
            d = $urandom();
            cycle(v, d, r, f);
            checks++;
            if (occupancy !== 2'(exp_q.size()) || in_ready !== (exp_q.size() < 2) ||
                out_valid !== (exp_q.size() > 0) || out_data !== exp_shown) begin
                errors++;
                $display("FAIL random[%0d] got occ %0d rdy %b vld %b data %h exp occ %0d rdy %b vld %b data %h",
                         i, occupancy, in_ready, out_valid, out_data, exp_q.size(),
                         (exp_q.size() < 2), (exp_q.size() > 0), exp_shown);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_push_pop();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
